instr_fetch: RTL

Instruction fetch unit for the MIPS-1 core. It holds the program counter and issues single-word reads to instruction memory. It buffers the returned word and presents it, with its PC, to the decode stage over a valid/ready handshake. Branch/jump redirects from execute retarget the PC and squash any in-flight or buffered instruction.

---
 rtl/mips_pkg.sv | 16 +
 rtl/fetch_buf.sv | 36 +++
 rtl/instr_fetch.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS-1 core definitions: fetch FSM states, widths and the reset vector.
package mips_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [31:0] RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    HOLD,
    FAULT
  } fetch_state_e;

endpackage

// File: rtl/fetch_buf.sv
// Single-entry holding register for a fetched instruction and its PC.
// Flush beats load, load beats pop; data/PC are retained after pop so outputs stay quiet.
module fetch_buf
  import mips_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic               load,
  input  logic               pop,
  input  logic               flush,
  input  logic [INSTR_W-1:0] dataIn,
  input  logic [ADDR_W-1:0]  pcIn,
  output logic               valid,
  output logic [INSTR_W-1:0] data,
  output logic [ADDR_W-1:0]  pc
);

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid <= 1'b0;
      data  <= '0;
      pc    <= '0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= dataIn;
      pc    <= pcIn;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// MIPS-1 instruction fetch: PC, single outstanding imem read, one-entry buffer to decode.
// Optional misaligned-redirect trap enabled with `define FETCH_MISALIGN_EN.
//
// state | meaning
// IDLE  | reset state, moves to REQ next cycle
// REQ   | imem request driven at pc, waiting for grant
// WAIT  | request granted, waiting for rvalid (drop marks a squashed response)
// HOLD  | buffered instruction offered to decode
// FAULT | misaligned redirect seen; fetch halted until reset
module instr_fetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_VECTOR)
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  output logic              imem_req_o,
  output logic [ADDR_W-1:0] imem_addr_o,
  input  logic              imem_gnt_i,
  input  logic              imem_rvalid_i,
  input  logic [31:0]       imem_rdata_i,
  output logic              instr_valid_o,
  output logic [31:0]       instr_o,
  output logic [ADDR_W-1:0] instr_pc_o,
  input  logic              instr_ready_i,
  input  logic              redirect_i,
  input  logic [ADDR_W-1:0] redirect_pc_i,
  output logic              fault_o
);

  fetch_state_e      stateQ, stateD;
  logic [ADDR_W-1:0] pcQ, pcD;
  logic              dropQ, dropD;
  logic              bufLoad, bufPop, bufFlush;
  logic [ADDR_W-1:0] targetPc;
  logic              misaligned;

`ifdef FETCH_MISALIGN_EN
  assign targetPc   = redirect_pc_i;
  assign misaligned = redirect_i && (redirect_pc_i[1:0] != 2'b00);
`else
  logic unusedLowBits;
  assign unusedLowBits = ^redirect_pc_i[1:0];
  assign targetPc      = {redirect_pc_i[ADDR_W-1:2], 2'b00};
  assign misaligned    = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      stateQ <= IDLE;
      pcQ    <= RESET_PC;
      dropQ  <= 1'b0;
    end else begin
      stateQ <= stateD;
      pcQ    <= pcD;
      dropQ  <= dropD;
    end
  end

  always_comb begin
    stateD     = stateQ;
    pcD        = pcQ;
    dropD      = dropQ;
    bufLoad    = 1'b0;
    bufPop     = 1'b0;
    bufFlush   = 1'b0;
    imem_req_o = 1'b0;

    case (stateQ)
      IDLE: stateD = REQ;
      REQ: begin
        imem_req_o = 1'b1;
        if (imem_gnt_i) begin
          stateD = WAIT;
          // a redirect racing the grant leaves a stale response in flight
          if (redirect_i) dropD = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rvalid_i) begin
          if (dropQ || redirect_i) begin
            dropD  = 1'b0;
            stateD = REQ;
          end else begin
            bufLoad = 1'b1;
            stateD  = HOLD;
          end
        end else if (redirect_i) begin
          dropD = 1'b1;
        end
      end
      HOLD: begin
        if (instr_ready_i) begin
          bufPop = 1'b1;
          pcD    = pcQ + ADDR_W'(PC_STEP);
          stateD = REQ;
        end
      end
      FAULT: ;
      default: stateD = IDLE;
    endcase

    if (redirect_i && stateQ != FAULT) begin
      pcD = targetPc;
      if (stateQ == HOLD) begin
        bufFlush = 1'b1;
        stateD   = REQ;
      end
    end

    // only reachable when the trap is compiled in
    if (misaligned && stateQ != FAULT) begin
      stateD   = FAULT;
      bufFlush = 1'b1;
      dropD    = 1'b0;
    end
  end

  assign imem_addr_o = pcQ;

`ifdef FETCH_MISALIGN_EN
  assign fault_o = (stateQ == FAULT);
`else
  assign fault_o = 1'b0;
`endif

  fetch_buf #(
    .ADDR_W(ADDR_W)
  ) u_buf (
    .clk    (clk_i),
    .rstN   (rst_n_i),
    .load   (bufLoad),
    .pop    (bufPop),
    .flush  (bufFlush),
    .dataIn (imem_rdata_i),
    .pcIn   (pcQ),
    .valid  (instr_valid_o),
    .data   (instr_o),
    .pc     (instr_pc_o)
  );

endmodule
